crop_window_sequencer: RTL and testbench

Front-end controller for the crop + Gaussian inference core. It receives a full raw image as a pixel stream and starts the core with a single `ap_start` pulse. It forwards only the pixels inside the configured crop window to the core's input stream, then waits for the core's `ap_done` before reporting frame completion. It sits between the image source and the core's pixel input port, and replaces the start/stream sequencing that is otherwise hand-driven in simulation.

---
 rtl/crop_window_sequencer.sv | 178 +++++++++++++++++
 tb/tb_crop_window_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crop_window_sequencer.sv
// Front-end sequencer for the crop + Gaussian core: pulses ap_start, forwards only in-window raster pixels,
// then waits for ap_done. Optional macro CROP_RUNTIME_ORIGIN_EN adds clamped cfg_y1/cfg_x1 origin ports.
module crop_window_sequencer #(
    parameter int DATA_W   = 16,
    parameter int IN_ROWS  = 100,
    parameter int IN_COLS  = 160,
    parameter int OUT_ROWS = 48,
    parameter int OUT_COLS = 48,
    parameter int Y_1      = 10,
    parameter int X_1      = 10
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst,
`ifdef CROP_RUNTIME_ORIGIN_EN
    input  logic [$clog2(IN_ROWS)-1:0] cfg_y1,
    input  logic [$clog2(IN_COLS)-1:0] cfg_x1,
`endif
    input  logic                       frame_go,
    output logic                       busy,
    output logic                       frame_done,
    input  logic [DATA_W-1:0]          s_tdata,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    output logic [DATA_W-1:0]          m_tdata,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic                       core_ap_start,
    input  logic                       core_ap_done
);

    localparam int ROW_W = $clog2(IN_ROWS);
    localparam int COL_W = $clog2(IN_COLS);
    localparam logic [ROW_W:0]   ROW_SPAN = (ROW_W+1)'(OUT_ROWS - 1);
    localparam logic [COL_W:0]   COL_SPAN = (COL_W+1)'(OUT_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ROW_W-1:0]    r_row;
    logic [ROW_W-1:0]    r_y1;
    logic [ROW_W-1:0]    w_org_y1;
    logic [COL_W-1:0]    r_col;
    logic [COL_W-1:0]    r_x1;
    logic [COL_W-1:0]    w_org_x1;
    logic                r_done_latch;
    logic                r_m_tvalid;
    logic [DATA_W-1:0]   r_m_tdata;
    logic                w_s_tready;
    logic                w_accept;
    logic                w_in_win;
    logic                w_last_beat;

    if ((Y_1 + OUT_ROWS > IN_ROWS) || (X_1 + OUT_COLS > IN_COLS)) begin : g_bad_window
        $error("crop_window_sequencer: crop window does not fit inside the input image");
    end

`ifdef CROP_RUNTIME_ORIGIN_EN
    // Origins beyond the last legal window position are pulled back so the window stays inside the image.
    localparam logic [ROW_W-1:0] Y_MAX = ROW_W'(IN_ROWS - OUT_ROWS);
    localparam logic [COL_W-1:0] X_MAX = COL_W'(IN_COLS - OUT_COLS);
    assign w_org_y1 = (cfg_y1 > Y_MAX) ? Y_MAX : cfg_y1;
    assign w_org_x1 = (cfg_x1 > X_MAX) ? X_MAX : cfg_x1;
`else
    assign w_org_y1 = ROW_W'(Y_1);
    assign w_org_x1 = COL_W'(X_1);
`endif

    // Bounds are compared one bit wider so origin + span cannot wrap.
    assign w_in_win = ({1'b0, r_row} >= {1'b0, r_y1}) && ({1'b0, r_row} <= ({1'b0, r_y1} + ROW_SPAN)) &&
                      ({1'b0, r_col} >= {1'b0, r_x1}) && ({1'b0, r_col} <= ({1'b0, r_x1} + COL_SPAN));
    assign w_last_beat = (r_row == ROW_LAST) && (r_col == COL_LAST);
    assign w_accept    = s_tvalid && w_s_tready;
    assign s_tready    = w_s_tready;
    assign m_tvalid    = r_m_tvalid;
    assign m_tdata     = r_m_tdata;

    // State register.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and state-decoded control outputs.
    always_comb begin
        w_next        = r_state;
        busy          = 1'b1;
        frame_done    = 1'b0;
        core_ap_start = 1'b0;
        w_s_tready    = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (frame_go) begin
                    w_next = S_START;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_START: begin
                core_ap_start = 1'b1;
                w_next        = S_STREAM;
            end
            S_STREAM: begin
                w_s_tready = !r_m_tvalid || m_tready;
                if (s_tvalid && w_s_tready && w_last_beat) begin
                    w_next = S_DRAIN;
                end else begin
                    w_next = S_STREAM;
                end
            end
            S_DRAIN: begin
                if (!r_m_tvalid && r_done_latch) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_DRAIN;
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                w_next     = S_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    // Raster counters, crop origin, core-done latch and the output pixel register.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_row        <= '0;
            r_col        <= '0;
            r_y1         <= '0;
            r_x1         <= '0;
            r_done_latch <= 1'b0;
            r_m_tvalid   <= 1'b0;
            r_m_tdata    <= '0;
        end else if (r_state == S_START) begin
            r_row        <= '0;
            r_col        <= '0;
            r_y1         <= w_org_y1;
            r_x1         <= w_org_x1;
            r_done_latch <= 1'b0;
        end else begin
            if (core_ap_done && (r_state != S_IDLE)) begin
                r_done_latch <= 1'b1;
            end
            if (w_accept) begin
                if (r_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= w_last_beat ? '0 : (r_row + 1'b1);
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            if (w_accept && w_in_win) begin
                r_m_tdata  <= s_tdata;
                r_m_tvalid <= 1'b1;
            end else if (m_tready) begin
                r_m_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_crop_window_sequencer.sv
// Randomized bench for crop_window_sequencer: ramp image in, cropped raster compared with a window model.
module tb_crop_window_sequencer;

    localparam int DATA_W   = 16;
    localparam int IN_ROWS  = 100;
    localparam int IN_COLS  = 160;
    localparam int OUT_ROWS = 48;
    localparam int OUT_COLS = 48;
    localparam int Y_1      = 10;
    localparam int X_1      = 10;
    localparam int N_PIX    = IN_ROWS * IN_COLS;

    logic              ap_clk = 1'b0;
    logic              ap_rst;
    logic              frame_go;
    logic              busy;
    logic              frame_done;
    logic [DATA_W-1:0] s_tdata;
    logic              s_tvalid;
    logic              s_tready;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              core_ap_start;
    logic              core_ap_done;
`ifdef CROP_RUNTIME_ORIGIN_EN
    logic [6:0]        cfg_y1;
    logic [7:0]        cfg_x1;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    int obs_q[$];
    int go_cyc, start_cyc, n_start, n_fdone, fdone_cyc, last_acc, done_cyc, n_acc;
    bit wait_bad, timeout;
    logic busy_after;

    always #5 ap_clk = ~ap_clk;

    crop_window_sequencer #(
        .DATA_W(DATA_W), .IN_ROWS(IN_ROWS), .IN_COLS(IN_COLS),
        .OUT_ROWS(OUT_ROWS), .OUT_COLS(OUT_COLS), .Y_1(Y_1), .X_1(X_1)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst(ap_rst),
`ifdef CROP_RUNTIME_ORIGIN_EN
        .cfg_y1(cfg_y1),
        .cfg_x1(cfg_x1),
`endif
        .frame_go(frame_go),
        .busy(busy),
        .frame_done(frame_done),
        .s_tdata(s_tdata),
        .s_tvalid(s_tvalid),
        .s_tready(s_tready),
        .m_tdata(m_tdata),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .core_ap_start(core_ap_start),
        .core_ap_done(core_ap_done)
    );

    // Reference: every raw pixel of the window, raster order, value = row*IN_COLS+col.
    function automatic void build_expected(input int y, input int x);
        exp_q.delete();
        for (int r = y; r < y + OUT_ROWS; r++)
            for (int c = x; c < x + OUT_COLS; c++)
                exp_q.push_back(r * IN_COLS + c);
    endfunction

    // Drives one frame and records what the DUT does. done_mode 0: ap_done on cycle done_param;
    // done_mode 1: ap_done done_param cycles after the last raw pixel. Stops early at rst_pixel accepts.
    task automatic drive_frame(input int vpct, input int rpct, input int done_mode, input int done_param,
                               input int go_again, input int rst_pixel);
        int cyc;
        int tail;
        cyc = 0; tail = -1;
        obs_q.delete();
        n_start = 0; n_fdone = 0; fdone_cyc = -1; start_cyc = -1; last_acc = -1;
        done_cyc = -1; n_acc = 0; wait_bad = 1'b0; timeout = 1'b0; busy_after = 1'b1; go_cyc = 1;
        forever begin
            @(negedge ap_clk);
            cyc++;
            frame_go     = (cyc == 1) || (cyc == go_again);
            s_tvalid     = (int'($urandom_range(99)) < vpct);
            s_tdata      = DATA_W'(n_acc);
            m_tready     = (int'($urandom_range(99)) < rpct);
            core_ap_done = (done_mode == 0) ? (cyc == done_param)
                                            : ((last_acc >= 0) && (cyc == last_acc + done_param));
            if (core_ap_done) done_cyc = cyc;
            #1;
            if (core_ap_start) begin
                n_start++;
                if (start_cyc < 0) start_cyc = cyc;
            end
            if (frame_done) begin
                n_fdone++;
                if (fdone_cyc < 0) fdone_cyc = cyc;
            end
            if (m_tvalid && m_tready) obs_q.push_back(int'(m_tdata));
            if ((done_mode == 1) && (last_acc >= 0) && (done_cyc < 0) && (!busy || frame_done)) wait_bad = 1'b1;
            if (s_tvalid && s_tready) begin
                n_acc++;
                if (n_acc == N_PIX) last_acc = cyc;
            end
            if (cyc == tail) begin
                busy_after = busy;
                @(negedge ap_clk);
                frame_go = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0; core_ap_done = 1'b0;
                break;
            end
            if (frame_done && (tail < 0)) tail = cyc + 1;
            if ((rst_pixel >= 0) && (n_acc >= rst_pixel)) break;
            if (cyc > 60000) begin
                timeout = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge ap_clk);
        ap_rst = 1'b0;
        #1;
        n_checks++;
        if ({busy, frame_done, s_tready, m_tvalid, core_ap_start} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, need 00000", {busy, frame_done, s_tready, m_tvalid, core_ap_start});
        end
        n_checks++;
        if (m_tdata !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_tdata: got %0d, need 0", m_tdata);
        end
    endtask

    task automatic test_full_rate();
        int bad;
        build_expected(Y_1, X_1);
        drive_frame(100, 100, 0, 500, 100, -1);
        bad = -1;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            if ((bad < 0) && (obs_q[i] != exp_q[i])) bad = i;
        n_checks++;
        if (timeout) begin n_fail++; $display("FAIL full_timeout: frame did not finish, got %0d pixels", obs_q.size()); end
        n_checks++;
        if (obs_q.size() != OUT_ROWS * OUT_COLS) begin
            n_fail++; $display("FAIL full_count: got %0d outputs, need %0d", obs_q.size(), OUT_ROWS * OUT_COLS);
        end
        n_checks++;
        if ((obs_q.size() == 0) || (obs_q[0] != 1610)) begin
            n_fail++; $display("FAIL full_first: got %0d, need 1610", (obs_q.size() > 0) ? obs_q[0] : -1);
        end
        n_checks++;
        if ((obs_q.size() == 0) || (obs_q[obs_q.size()-1] != 9177)) begin
            n_fail++; $display("FAIL full_last: got %0d, need 9177", (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : -1);
        end
        n_checks++;
        if (bad >= 0) begin
            n_fail++; $display("FAIL full_seq: index %0d got %0d, need %0d", bad, obs_q[bad], exp_q[bad]);
        end
        n_checks++;
        if (n_start != 1) begin n_fail++; $display("FAIL full_start_count: got %0d, need 1", n_start); end
        n_checks++;
        if (start_cyc != go_cyc + 1) begin n_fail++; $display("FAIL full_start_cycle: got %0d, need %0d", start_cyc, go_cyc + 1); end
        n_checks++;
        if (n_fdone != 1) begin n_fail++; $display("FAIL full_done_count: got %0d, need 1", n_fdone); end
        n_checks++;
        if (fdone_cyc != last_acc + 2) begin n_fail++; $display("FAIL full_done_cycle: got %0d, need %0d", fdone_cyc, last_acc + 2); end
        n_checks++;
        if (fdone_cyc - go_cyc != N_PIX + 3) begin
            n_fail++; $display("FAIL full_frame_time: got %0d, need %0d", fdone_cyc - go_cyc, N_PIX + 3);
        end
        n_checks++;
        if (busy_after !== 1'b0) begin n_fail++; $display("FAIL full_go_ignored: busy after done got %b, need 0", busy_after); end
    endtask

    task automatic test_random_handshake();
        int bad;
        build_expected(Y_1, X_1);
        drive_frame(50, 50, 0, 500, -1, -1);
        bad = -1;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            if ((bad < 0) && (obs_q[i] != exp_q[i])) bad = i;
        n_checks++;
        if (timeout) begin n_fail++; $display("FAIL rand_timeout: frame did not finish, got %0d pixels", obs_q.size()); end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rand_count: got %0d outputs, need %0d", obs_q.size(), exp_q.size());
        end
        n_checks++;
        if (bad >= 0) begin
            n_fail++; $display("FAIL rand_seq: index %0d got %0d, need %0d", bad, obs_q[bad], exp_q[bad]);
        end
        n_checks++;
        if ((n_fdone != 1) || (fdone_cyc != last_acc + 2)) begin
            n_fail++; $display("FAIL rand_done: got %0d pulses at %0d, need 1 at %0d", n_fdone, fdone_cyc, last_acc + 2);
        end
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        build_expected(Y_1, X_1);
        drive_frame(100, 100, 0, 300, -1, 5000);
        @(negedge ap_clk);
        ap_rst = 1'b1; s_tvalid = 1'b1; m_tready = 1'b0; core_ap_done = 1'b1; frame_go = 1'b0;
        @(negedge ap_clk);
        ap_rst = 1'b0; s_tvalid = 1'b0; core_ap_done = 1'b0;
        #1;
        n_checks++;
        if ({busy, frame_done, s_tready, m_tvalid, core_ap_start} !== 5'b00000) begin
            n_fail++;
            $display("FAIL midrst_ctrl: got %b, need 00000", {busy, frame_done, s_tready, m_tvalid, core_ap_start});
        end
        n_checks++;
        if (m_tdata !== 16'd0) begin n_fail++; $display("FAIL midrst_tdata: got %0d, need 0", m_tdata); end
        drive_frame(100, 100, 1, 200, -1, -1);
        bad = -1;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            if ((bad < 0) && (obs_q[i] != exp_q[i])) bad = i;
        n_checks++;
        if ((obs_q.size() != exp_q.size()) || (bad >= 0)) begin
            n_fail++; $display("FAIL midrst_frame2: got %0d outputs (first bad %0d), need %0d", obs_q.size(), bad, exp_q.size());
        end
        n_checks++;
        if (wait_bad || timeout) begin n_fail++; $display("FAIL late_done_wait: busy dropped or done early, got 1, need 0"); end
        n_checks++;
        if ((n_fdone != 1) || (fdone_cyc != done_cyc + 2)) begin
            n_fail++; $display("FAIL late_done_cycle: got %0d pulses at %0d, need 1 at %0d", n_fdone, fdone_cyc, done_cyc + 2);
        end
    endtask

`ifdef CROP_RUNTIME_ORIGIN_EN
    task automatic test_runtime_origin();
        int y;
        int x;
        int bad;
        cfg_y1 = 7'd90;
        cfg_x1 = 8'd0;
        y = (90 > IN_ROWS - OUT_ROWS) ? (IN_ROWS - OUT_ROWS) : 90;
        x = 0;
        build_expected(y, x);
        drive_frame(100, 100, 0, 500, 100, -1);
        bad = -1;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            if ((bad < 0) && (obs_q[i] != exp_q[i])) bad = i;
        n_checks++;
        if ((obs_q.size() == 0) || (obs_q[0] != 8320)) begin
            n_fail++; $display("FAIL rt_first: got %0d, need 8320", (obs_q.size() > 0) ? obs_q[0] : -1);
        end
        n_checks++;
        if ((obs_q.size() != exp_q.size()) || (bad >= 0)) begin
            n_fail++; $display("FAIL rt_seq: got %0d outputs (first bad %0d), need %0d", obs_q.size(), bad, exp_q.size());
        end
        n_checks++;
        if ((n_start != 1) || (busy_after !== 1'b0)) begin
            n_fail++; $display("FAIL rt_go_ignored: got %0d starts busy_after %b, need 1 and 0", n_start, busy_after);
        end
    endtask
`endif

    initial begin
        ap_rst = 1'b1; frame_go = 1'b0; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0; core_ap_done = 1'b0;
`ifdef CROP_RUNTIME_ORIGIN_EN
        cfg_y1 = 7'd0;
        cfg_x1 = 8'd0;
`endif
        test_reset();
        test_full_rate();
        test_random_handshake();
        test_reset_mid_frame();
`ifdef CROP_RUNTIME_ORIGIN_EN
        test_runtime_origin();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
